// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with valid/ready handshakes on both sides.
// A single adder retires one multiplier bit per cycle, LSB first, over WIDTH cycles.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CW-1:0]        cnt_reg;
  logic [2*WIDTH-1:0]   prod_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;
  logic [2*WIDTH-1:0]   acc_next;

  // The only adder: add the shifted multiplicand when the current multiplier bit is set.
  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg     <= IDLE;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      prod_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mcand_reg    <= {{WIDTH{1'b0}}, x};
            mplier_reg   <= y;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
          end
        end
        RUN: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          // Fixed latency: no early exit even when the remaining multiplier bits are zero.
          if (cnt_reg == CNT_LAST) begin
            prod_reg      <= acc_next;
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign prod      = prod_reg;

endmodule
